pc_sequencer: RTL

//  Owns the fetch PC register and sequences the front end around the branch unit.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_seq_perf.sv | 38 +++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the fetch PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } pc_seq_state_t;

   localparam int PC_INC = 4;
   localparam int PERF_W = 32;

endpackage : pc_seq_pkg

`default_nettype wire

// File: rtl/pc_seq_perf.sv
// ============================================================================
// Module      : pc_seq_perf
// Description : Free-running performance counters for accepted redirects and
//               stalled fetch cycles; both wrap silently.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq_perf
   import pc_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              Redir_Inc_i,
   input  logic              Stall_Inc_i,
   output logic [PERF_W-1:0] Redir_Cnt_o,
   output logic [PERF_W-1:0] Stall_Cnt_o
);

   logic [PERF_W-1:0] redir_cnt_q;
   logic [PERF_W-1:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         redir_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (Redir_Inc_i) redir_cnt_q <= redir_cnt_q + PERF_W'(1);
         if (Stall_Inc_i) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
   end

   assign Redir_Cnt_o = redir_cnt_q;
   assign Stall_Cnt_o = stall_cnt_q;

endmodule : pc_seq_perf

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC register and front-end sequencer (RUN/FLUSH/HALT)
//               around the branch unit. Optional perf counters are built when
//               the macro PC_SEQ_PERF_EN is defined; otherwise they read 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_W         = 9,
   parameter int FLUSH_CYCLES = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              Stall,
   input  logic              PcSel,
   input  logic [31:0]       BrPC,
   input  logic              HaltSel,
   input  logic              Resume,
   output logic [PC_W-1:0]   Cur_PC,
   output logic              Fetch_En,
   output logic              Flush,
   output logic              Halted,
   output logic              Misaligned,
   output logic [PERF_W-1:0] Redir_Cnt,
   output logic [PERF_W-1:0] Stall_Cnt
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   pc_seq_state_t    state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mis_q, mis_d;
   logic             redir_acc;
   logic             stall_cyc;

   // Target bits above the PC width are dropped by design.
   logic w_unused_brpc;
   assign w_unused_brpc = ^BrPC[31:PC_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= '0;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      mis_d     = mis_q;
      Flush     = 1'b0;
      Fetch_En  = 1'b0;
      redir_acc = 1'b0;
      stall_cyc = 1'b0;
      unique case (state_q)
         RUN: begin
            Fetch_En  = ~Stall;
            stall_cyc = Stall;
            if (HaltSel) begin
               Flush   = 1'b1;
               state_d = HALT;
            end else if (PcSel) begin
               Flush = 1'b1;
               if (BrPC[1:0] != 2'b00) begin
                  mis_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  redir_acc = 1'b1;
                  pc_d      = BrPC[PC_W-1:0];
                  cnt_d     = CNT_W'(FLUSH_CYCLES - 1);
                  state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
               end
            end else if (!Stall) begin
               pc_d = pc_q + PC_W'(PC_INC);
            end
         end
         // Redirect/halt requests here come from squashed instructions.
         FLUSH: begin
            Flush     = 1'b1;
            Fetch_En  = ~Stall;
            stall_cyc = Stall;
            if (!Stall) pc_d = pc_q + PC_W'(PC_INC);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = RUN;
         end
         HALT: begin
            if (Resume) begin
               pc_d    = pc_q + PC_W'(PC_INC);
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign Cur_PC     = pc_q;
   assign Halted     = (state_q == HALT);
   assign Misaligned = mis_q;

`ifdef PC_SEQ_PERF_EN
   pc_seq_perf u_perf (
      .clk         (clk),
      .reset       (reset),
      .Redir_Inc_i (redir_acc),
      .Stall_Inc_i (stall_cyc),
      .Redir_Cnt_o (Redir_Cnt),
      .Stall_Cnt_o (Stall_Cnt)
   );
`else
   logic w_unused_perf;
   assign w_unused_perf = redir_acc ^ stall_cyc;
   assign Redir_Cnt     = '0;
   assign Stall_Cnt     = '0;
`endif

endmodule : pc_sequencer

`default_nettype wire
